// File: rtl/butterfly_combine.sv
// butterfly_combine
// Radix-2 DIT butterfly sequencer/combiner wrapped around a shared 16x16
// signed combinational multiplier.
//   - Accepts one operand set (A, B, W) per transaction.
//   - Forms B*W over four multiplier cycles.
//   - Emits X = (A + B*W)/2 and Y = (A - B*W)/2, rounded.
// Optional feature macro: BUTTERFLY_SAT_EN.
//   - Defined:   outputs saturate to the signed LENGTH-bit range.
//   - Undefined: outputs wrap, keeping the low LENGTH bits.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | ready for an operand set; registers A, B, W on accept
// MUL0  | multiplier gets Br*Wr; acc_r = product
// MUL1  | multiplier gets Bi*Wi; acc_r -= product
// MUL2  | multiplier gets Br*Wi; acc_i = product
// MUL3  | multiplier gets Bi*Wr; acc_i += product
// SUM   | round the products, combine with A, register X/Y
// OUT   | result valid and held until downstream accepts it

module butterfly_combine #(
    parameter int LENGTH = 16
) (
    input  logic                xClk,
    input  logic                xRst,
    input  logic                xInValid,
    output logic                xInReady,
    input  logic [LENGTH-1:0]   xAr,
    input  logic [LENGTH-1:0]   xAi,
    input  logic [LENGTH-1:0]   xBr,
    input  logic [LENGTH-1:0]   xBi,
    input  logic [LENGTH-1:0]   xWr,
    input  logic [LENGTH-1:0]   xWi,
    output logic [LENGTH-1:0]   xMultiplicand,
    output logic [LENGTH-1:0]   xMultiplier,
    input  logic [2*LENGTH-1:0] xProduct,
    output logic                xOutValid,
    input  logic                xOutReady,
    output logic [LENGTH-1:0]   xXr,
    output logic [LENGTH-1:0]   xXi,
    output logic [LENGTH-1:0]   xYr,
    output logic [LENGTH-1:0]   xYi
);

    // Accumulator, rounded-product and sum widths.
    localparam int AW = 2*LENGTH + 1;
    localparam int PW = LENGTH + 2;
    localparam int SW = LENGTH + 3;

    // Half an LSB of the Q1.15 product, added before the arithmetic shift.
    localparam logic signed [AW-1:0] RND_P = AW'(1) <<< (LENGTH-2);

`ifdef BUTTERFLY_SAT_EN
    localparam logic signed [SW-1:0] SAT_MAX = SW'((1 << (LENGTH-1)) - 1);
    localparam logic signed [SW-1:0] SAT_MIN = ~SAT_MAX;
`endif

    typedef enum logic [2:0] {
        IDLE,
        MUL0,
        MUL1,
        MUL2,
        MUL3,
        SUM,
        OUT
    } state_t;

    state_t state;
    state_t state_nxt;

    logic signed [LENGTH-1:0] ar;
    logic signed [LENGTH-1:0] ai;
    logic signed [LENGTH-1:0] br;
    logic signed [LENGTH-1:0] bi;
    logic signed [LENGTH-1:0] wr;
    logic signed [LENGTH-1:0] wi;

    logic signed [AW-1:0]     acc_r;
    logic signed [AW-1:0]     acc_i;
    logic signed [AW-1:0]     prod_ext;
    logic signed [PW-1:0]     p_r;
    logic signed [PW-1:0]     p_i;

    // P = (acc + 2^(LENGTH-2)) >>> (LENGTH-1), kept at LENGTH+2 bits.
    function automatic logic signed [PW-1:0] round_prod(
        input logic signed [AW-1:0] acc
    );
        logic signed [AW-1:0] t;
        t = (acc + RND_P) >>> (LENGTH-1);
        return t[PW-1:0];
    endfunction

    // out = (A +/- P + 1) >>> 1, i.e. halve with round half up.
    function automatic logic signed [SW-1:0] half_round(
        input logic signed [LENGTH-1:0] a,
        input logic signed [PW-1:0]     p,
        input logic                     sub
    );
        logic signed [SW-1:0] a_x;
        logic signed [SW-1:0] p_x;
        logic signed [SW-1:0] s;
        a_x = SW'(a);
        p_x = SW'(p);
        s   = sub ? (a_x - p_x) : (a_x + p_x);
        return (s + SW'(1)) >>> 1;
    endfunction

    // Narrow a rounded result to the output width.
    function automatic logic [LENGTH-1:0] reduce(
        input logic signed [SW-1:0] v
    );
`ifdef BUTTERFLY_SAT_EN
        if (v > SAT_MAX) begin
            return SAT_MAX[LENGTH-1:0];
        end else if (v < SAT_MIN) begin
            return SAT_MIN[LENGTH-1:0];
        end else begin
            return v[LENGTH-1:0];
        end
`else
        return v[LENGTH-1:0];
`endif
    endfunction

    assign prod_ext = $signed({xProduct[2*LENGTH-1], xProduct});
    assign p_r      = round_prod(acc_r);
    assign p_i      = round_prod(acc_i);

    // State register.
    always_ff @(posedge xClk) begin
        if (xRst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, handshake flags and multiplier operand steering.
    always_comb begin
        state_nxt     = state;
        xInReady      = 1'b0;
        xOutValid     = 1'b0;
        xMultiplicand = '0;
        xMultiplier   = '0;
        case (state)
            IDLE: begin
                xInReady = 1'b1;
                if (xInValid) begin
                    state_nxt = MUL0;
                end
            end
            MUL0: begin
                xMultiplicand = br;
                xMultiplier   = wr;
                state_nxt     = MUL1;
            end
            MUL1: begin
                xMultiplicand = bi;
                xMultiplier   = wi;
                state_nxt     = MUL2;
            end
            MUL2: begin
                xMultiplicand = br;
                xMultiplier   = wi;
                state_nxt     = MUL3;
            end
            MUL3: begin
                xMultiplicand = bi;
                xMultiplier   = wr;
                state_nxt     = SUM;
            end
            SUM: begin
                state_nxt = OUT;
            end
            OUT: begin
                xOutValid = 1'b1;
                if (xOutReady) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Operand capture, product accumulation and result registers.
    always_ff @(posedge xClk) begin
        if (xRst) begin
            ar    <= '0;
            ai    <= '0;
            br    <= '0;
            bi    <= '0;
            wr    <= '0;
            wi    <= '0;
            acc_r <= '0;
            acc_i <= '0;
            xXr   <= '0;
            xXi   <= '0;
            xYr   <= '0;
            xYi   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (xInValid) begin
                        ar <= xAr;
                        ai <= xAi;
                        br <= xBr;
                        bi <= xBi;
                        wr <= xWr;
                        wi <= xWi;
                    end
                end
                MUL0: acc_r <= prod_ext;
                MUL1: acc_r <= acc_r - prod_ext;
                MUL2: acc_i <= prod_ext;
                MUL3: acc_i <= acc_i + prod_ext;
                SUM: begin
                    xXr <= reduce(half_round(ar, p_r, 1'b0));
                    xXi <= reduce(half_round(ai, p_i, 1'b0));
                    xYr <= reduce(half_round(ar, p_r, 1'b1));
                    xYi <= reduce(half_round(ai, p_i, 1'b1));
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_butterfly_combine.sv
// Testbench for butterfly_combine: directed vectors with hand-computed
// results plus a short random back-to-back run checked against a
// reference model; expectations are queued at issue time and consumed
// by an independent output monitor.

module tb_butterfly_combine;

    localparam int L = 16;

    typedef struct packed {
        logic signed [L-1:0] xr;
        logic signed [L-1:0] xi;
        logic signed [L-1:0] yr;
        logic signed [L-1:0] yi;
    } exp_t;

`ifdef BUTTERFLY_SAT_EN
    localparam int XI_OVF = 32767;
`else
    localparam int XI_OVF = -16384;
`endif

    logic           xClk = 1'b0;
    logic           xRst;
    logic           xInValid;
    logic           xInReady;
    logic [L-1:0]   xAr, xAi, xBr, xBi, xWr, xWi;
    logic [L-1:0]   xMultiplicand, xMultiplier;
    logic [2*L-1:0] xProduct;
    logic           xOutValid;
    logic           xOutReady;
    logic [L-1:0]   xXr, xXi, xYr, xYi;

    logic signed [2*L-1:0] m_a, m_b;

    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t sb_q[$];

    // Monitor bookkeeping.
    int edge_n = 0;
    int acc_edge = 0;
    int hs_edge = 0;
    bit in_flight = 0;
    bit prev_valid = 0;
    bit chk_interval = 0;
    bit interval_armed = 0;
    bit chk_after_hs = 0;

    always #5 xClk = ~xClk;

    // Shared multiplier model.
    assign m_a      = {{L{xMultiplicand[L-1]}}, xMultiplicand};
    assign m_b      = {{L{xMultiplier[L-1]}}, xMultiplier};
    assign xProduct = m_a * m_b;

    butterfly_combine #(.LENGTH(L)) dut (
        .xClk(xClk),
        .xRst(xRst),
        .xInValid(xInValid),
        .xInReady(xInReady),
        .xAr(xAr),
        .xAi(xAi),
        .xBr(xBr),
        .xBi(xBi),
        .xWr(xWr),
        .xWi(xWi),
        .xMultiplicand(xMultiplicand),
        .xMultiplier(xMultiplier),
        .xProduct(xProduct),
        .xOutValid(xOutValid),
        .xOutReady(xOutReady),
        .xXr(xXr),
        .xXi(xXi),
        .xYr(xYr),
        .xYi(xYi)
    );

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(input int xr, input int xi, input int yr, input int yi);
        exp_t e;
        e.xr = 16'(xr);
        e.xi = 16'(xi);
        e.yr = 16'(yr);
        e.yi = 16'(yi);
        return e;
    endfunction

    function automatic logic signed [L-1:0] red(input longint v);
        logic [L-1:0] t;
`ifdef BUTTERFLY_SAT_EN
        if (v > 32767)  v = 32767;
        if (v < -32768) v = -32768;
`endif
        t = v[L-1:0];
        return $signed(t);
    endfunction

    function automatic exp_t model(input logic signed [L-1:0] ar, input logic signed [L-1:0] ai,
                                   input logic signed [L-1:0] br, input logic signed [L-1:0] bi,
                                   input logic signed [L-1:0] wr, input logic signed [L-1:0] wi);
        longint pr, pi, qr, qi;
        exp_t   e;
        pr = longint'(br) * longint'(wr) - longint'(bi) * longint'(wi);
        pi = longint'(br) * longint'(wi) + longint'(bi) * longint'(wr);
        qr = (pr + 16384) >>> 15;
        qi = (pi + 16384) >>> 15;
        e.xr = red((longint'(ar) + qr + 1) >>> 1);
        e.xi = red((longint'(ai) + qi + 1) >>> 1);
        e.yr = red((longint'(ar) - qr + 1) >>> 1);
        e.yi = red((longint'(ai) - qi + 1) >>> 1);
        return e;
    endfunction

    always @(posedge xClk) edge_n++;

    // Output monitor: latency, scoreboard pops, accept spacing.
    always @(negedge xClk) begin
        exp_t e;
        if (xRst) begin
            in_flight  = 0;
            prev_valid = 0;
        end else begin
            if (xOutValid && !prev_valid) begin
                if (!in_flight) chk("spurious_valid", 1, 0);
                else            chk("latency_cycles", edge_n - acc_edge + 1, 6);
            end
            if (xOutValid && xOutReady) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_output", 1, 0);
                end else begin
                    e = sb_q.pop_front();
                    chk("Xr", $signed(xXr), e.xr);
                    chk("Xi", $signed(xXi), e.xi);
                    chk("Yr", $signed(xYr), e.yr);
                    chk("Yi", $signed(xYi), e.yi);
                end
                hs_edge   = edge_n + 1;
                in_flight = 0;
            end
            if (xInValid && xInReady) begin
                if (chk_interval && interval_armed)
                    chk("accept_interval", edge_n + 1 - acc_edge, 7);
                if (chk_interval) interval_armed = 1;
                if (chk_after_hs) begin
                    chk("accept_after_handshake", edge_n + 1 - hs_edge, 1);
                    chk_after_hs = 0;
                end
                acc_edge  = edge_n + 1;
                in_flight = 1;
            end
            prev_valid = xOutValid;
        end
    end

    task automatic issue(input int ar, input int ai, input int br, input int bi,
                         input int wr, input int wi, input exp_t e, input bit push);
        @(posedge xClk);
        #1;
        xAr = 16'(ar); xAi = 16'(ai);
        xBr = 16'(br); xBi = 16'(bi);
        xWr = 16'(wr); xWi = 16'(wi);
        xInValid = 1'b1;
        if (push) sb_q.push_back(e);
    endtask

    // Returns 1 ns after the accepting edge, i.e. at the start of cycle 1.
    task automatic wait_accept();
        int k;
        for (k = 0; k < 60; k++) begin
            @(negedge xClk);
            if (xInReady) break;
        end
        if (k >= 60) begin
            chk("accept_timeout", 0, 1);
        end else begin
            @(posedge xClk);
            #1;
            xInValid = 1'b0;
        end
    endtask

    task automatic check_idle_zero(input string tag);
        chk({tag, "_in_ready"},  xInReady, 1);
        chk({tag, "_out_valid"}, xOutValid, 0);
        chk({tag, "_xr"}, xXr, 0);
        chk({tag, "_xi"}, xXi, 0);
        chk({tag, "_yr"}, xYr, 0);
        chk({tag, "_yi"}, xYi, 0);
        chk({tag, "_mcand"}, xMultiplicand, 0);
        chk({tag, "_mplier"}, xMultiplier, 0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e_bp;
        int   k;
        xRst = 1'b1; xInValid = 1'b0; xOutReady = 1'b1;
        xAr = '0; xAi = '0; xBr = '0; xBi = '0; xWr = '0; xWi = '0;

        // Reset values after the first edge.
        @(posedge xClk);
        #1;
        check_idle_zero("reset");
        repeat (2) @(posedge xClk);
        #1;
        xRst = 1'b0;

        // Basic case.
        issue(100, 50, 1000, 0, 16384, 0, mk(300, 25, -200, 25), 1);
        wait_accept();

        // Operand sequencing with distinct operands.
        issue(10, -20, 1000, -400, 16384, -8192, mk(205, -235, -195, 215), 1);
        wait_accept();
        for (int c = 1; c <= 7; c++) begin
            int em, ep;
            @(negedge xClk);
            case (c)
                1: begin em = 1000; ep = 16384; end
                2: begin em = -400; ep = -8192; end
                3: begin em = 1000; ep = -8192; end
                4: begin em = -400; ep = 16384; end
                default: begin em = 0; ep = 0; end
            endcase
            chk($sformatf("mcand_c%0d", c), $signed(xMultiplicand), em);
            chk($sformatf("mplier_c%0d", c), $signed(xMultiplier), ep);
            if (c == 5) chk("valid_c5", xOutValid, 0);
            if (c == 6) chk("valid_c6", xOutValid, 1);
        end

        // Overflow case, including the imaginary accumulator.
        issue(32767, 32767, -32768, -32768, -32768, -32768,
              mk(16384, XI_OVF, 16384, -16384), 1);
        wait_accept();
        repeat (5) @(negedge xClk);
        chk("acc_i_ovf", longint'(dut.acc_i), 64'sd2147483648);

        // Backpressure with the next set already presented.
        e_bp = mk(-1125, 1125, 125, 875);
        issue(-1000, 2000, -2000, 3000, 8192, 8192, e_bp, 1);
        wait_accept();
        xOutReady = 1'b0;
        issue(-3, 4, 32767, -32768, -16384, 16384, mk(-1, 16386, -2, -16382), 1);
        for (k = 0; k < 20; k++) begin
            @(negedge xClk);
            if (xOutValid) break;
        end
        chk("bp_valid_seen", xOutValid, 1);
        for (int h = 0; h < 10; h++) begin
            if (h > 0) @(negedge xClk);
            chk($sformatf("bp_valid_h%0d", h), xOutValid, 1);
            chk($sformatf("bp_ready_h%0d", h), xInReady, 0);
            chk($sformatf("bp_xr_h%0d", h), $signed(xXr), e_bp.xr);
            chk($sformatf("bp_xi_h%0d", h), $signed(xXi), e_bp.xi);
            chk($sformatf("bp_yr_h%0d", h), $signed(xYr), e_bp.yr);
            chk($sformatf("bp_yi_h%0d", h), $signed(xYi), e_bp.yi);
        end
        @(posedge xClk);
        #1;
        chk_after_hs = 1;
        xOutReady = 1'b1;
        wait_accept();
        repeat (8) @(posedge xClk);

        // Reset during MUL2: the set is discarded.
        issue(100, 50, 1000, 0, 16384, 0, mk(0, 0, 0, 0), 0);
        wait_accept();
        @(posedge xClk);
        #1;
        @(posedge xClk);
        #1;
        xRst = 1'b1;
        @(posedge xClk);
        #1;
        check_idle_zero("midreset");
        xRst = 1'b0;
        repeat (12) @(posedge xClk);
        #1;
        chk("midreset_no_output", sb_q.size(), 0);

        // Back-to-back random sets.
        chk_interval   = 1;
        interval_armed = 0;
        for (int i = 0; i < 8; i++) begin
            logic signed [L-1:0] r[6];
            for (int j = 0; j < 6; j++) r[j] = 16'($urandom);
            issue(r[0], r[1], r[2], r[3], r[4], r[5],
                  model(r[0], r[1], r[2], r[3], r[4], r[5]), 1);
            wait_accept();
        end

        for (k = 0; k < 100; k++) begin
            @(negedge xClk);
            if (sb_q.size() == 0 && !xOutValid) break;
        end
        chk("scoreboard_drained", sb_q.size(), 0);
        chk_interval = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
